ahb_multi_timer: RTL and testbench
==================================

// Module: ahb_multi_timer
// PURPOSE
//  AHB-Lite slave with NUM_CH independent down-counting timers. Each channel has a prescaler,
//  a one-shot or periodic mode, a sticky EXPIRED flag and an interrupt enable.
//  Replaces the single-channel game timer. Sits on the system AHB bus next to the other peripherals.
//  Drives a one-cycle done pulse per channel plus one combined interrupt line.
// PARAMETERS
//  NUM_CH     4   number of timer channels (1..8)
//  CNT_WIDTH  32  counter/LOAD width in bits (8..32); upper HWDATA/HRDATA bits are zero
//  PRE_WIDTH  8   prescaler field width (1..8)
// PORTS
//  HCLK       in   1          bus/system clock
//  HRESET     in   1          synchronous reset, active-high
//  HADDR      in   32         address; only HADDR[7:0] decoded
//  HWDATA     in   32         write data (data phase)
//  HSIZE      in   3          transfer size; only 3'b010 (word) writes take effect
//  HTRANS     in   2          transfer type; HTRANS[1]=1 means NONSEQ/SEQ
//  HWRITE     in   1          1=write, 0=read
//  HREADY     in   1          bus ready; qualifies the address phase
//  HSEL       in   1          slave select
//  HRDATA     out  32         read data (data phase)
//  HREADYOUT  out  1          always 1 (zero wait states)
//  done       out  NUM_CH     one-cycle pulse per channel on expiry
//  irq        out  1          OR over channels of (EXPIRED & IRQ_EN)
// BEHAVIOUR
//  Reset: all registers 0, done=0, irq=0, HRDATA=0, HREADYOUT=1, and all channels disabled.
//  Bus protocol:
//  - An address phase is valid when HSEL & HREADY & HTRANS[1]. On a valid phase, register
//    HADDR[7:0], HWRITE and (HSIZE==3'b010).
//  - A write commits at the end of the next cycle using HWDATA.
//  - On a read, HRDATA is valid in the data phase. It is taken from a register driven by the
//    stored address, so the read is one cycle after the address phase.
//  - Unmapped addresses read 0 and ignore writes.
//  Register map (channel c at c*0x10):
//  - +0x0 CTRL RW: [0] EN, [1] MODE (0=one-shot, 1=periodic), [2] IRQ_EN,
//    [8+:PRE_WIDTH] PRESCALE.
//  - +0x4 LOAD RW: [CNT_WIDTH-1:0] reload value.
//  - +0x8 VALUE RO: current count. Writes are ignored.
//  - +0xC STATUS: [0] EXPIRED, write 1 to clear.
//  - NUM_CH*0x10 IRQ_PEND RO: bit c = EXPIRED[c] & IRQ_EN[c].
//  Channel operation:
//  - Start: when a CTRL write changes EN from 0 to 1, VALUE<=LOAD and the prescaler is cleared
//    in the same commit cycle.
//  - Tick: while EN=1, the prescaler counts 0..PRESCALE. A tick happens on the cycle it equals
//    PRESCALE, then it wraps to 0. PRESCALE=0 gives a tick every cycle.
//  - On a tick with VALUE!=0: VALUE<=VALUE-1.
//  - On a tick with VALUE==0 (expiry): EXPIRED<=1 and done[c]=1 for exactly one cycle.
//    - periodic: VALUE<=LOAD.
//    - one-shot: EN<=0 and VALUE stays 0.
//  - Period: expiry occurs (LOAD+1)*(PRESCALE+1) cycles after the start.
//    With LOAD=0 in periodic mode, the channel expires on every tick.
//  - Writing LOAD while running does not touch VALUE; the new value is used at the next reload.
//  - Writing CTRL with EN=1 while EN is already 1 updates MODE/IRQ_EN/PRESCALE only, with no
//    restart. Narrowing PRESCALE below the prescaler's current count makes it wrap on the next
//    cycle.
//  - Writing EN=0 stops the channel immediately. VALUE and EXPIRED are held.
//  - A clear of EXPIRED and an expiry in the same cycle: the set wins, so EXPIRED=1.
//  - irq is registered, one cycle after EXPIRED or IRQ_EN changes. It holds until every enabled
//    EXPIRED is cleared.
//  - VALUE wraps never: it cannot decrement below 0.
//  - HRESET asserted mid-count or mid-transfer: everything returns to reset values on the next
//    edge, and any pending write is dropped.
// TESTING
//  1 Reset: hold HRESET 3 cycles -> all reads 0, done=0, irq=0, HREADYOUT=1 throughout.
//  2 One-shot: ch0 LOAD=5, CTRL=0x1 -> done[0] pulses once exactly 6 cycles after the commit.
//    Then VALUE=0, EN reads 0, and STATUS=1.
//  3 Periodic with prescaler: ch1 LOAD=3, CTRL=0x0203 (PRESCALE=2, periodic) ->
//    done[1] pulses every 12 cycles for 5 periods.
//  4 IRQ and W1C: ch2 periodic, LOAD=0, IRQ_EN -> irq=1 and IRQ_PEND=0x4. Writing STATUS=1
//    on an expiry cycle keeps EXPIRED=1. After EN=0 and STATUS=1, irq drops to 0.
//  5 Bus edges: HSIZE=byte write to LOAD -> LOAD unchanged. Read at unmapped 0xF0 -> 0.
//    Back-to-back write LOAD then read LOAD -> the new value is returned.
//  6 Mid-run reset: ch3 counting with LOAD=1000, assert HRESET at VALUE=500 ->
//    VALUE=0, EN=0 next cycle, and no done pulse.

Source files
------------

// File: rtl/ahb_multi_timer.sv
// AHB-Lite slave with NUM_CH independent prescaled down-counting timers, sticky expiry, done pulses and irq.
// Latency: writes commit at the end of the data phase; reads return in the data phase; done/irq are registered.
// Backpressure: none, HREADYOUT is tied high (zero wait states).
//
// Ports:
//   HCLK, HRESET            clock, synchronous active-high reset
//   HADDR/HWDATA/HSIZE/
//   HTRANS/HWRITE/HREADY/
//   HSEL                    AHB-Lite slave inputs (only HADDR[7:0] decoded, only word writes act)
//   HRDATA, HREADYOUT       read data (data phase), always-ready
//   done[NUM_CH]            one-cycle pulse per channel expiry
//   irq                     registered OR of (EXPIRED & IRQ_EN) over channels
//
// Register map, channel c at c*0x10:
//   +0x0 CTRL   [0] EN, [1] MODE (1=periodic), [2] IRQ_EN, [8+:PRE_WIDTH] PRESCALE
//   +0x4 LOAD   reload value
//   +0x8 VALUE  current count (read only)
//   +0xC STATUS [0] EXPIRED, write 1 to clear
//   NUM_CH*0x10 IRQ_PEND, bit c = EXPIRED[c] & IRQ_EN[c]
module ahb_multi_timer #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 32,
    parameter int PRE_WIDTH = 8
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [31:0]       HADDR,
    input  logic [31:0]       HWDATA,
    input  logic [2:0]        HSIZE,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic              HREADY,
    input  logic              HSEL,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic [NUM_CH-1:0] done,
    output logic              irq
);

    // ------------------------------------------------------------------
    // Address phase capture
    // ------------------------------------------------------------------
    logic       addr_vld;
    logic [7:0] addr_q;
    logic       wr_q;      // a word write is in its data phase
    logic       rd_q;      // a read is in its data phase

    assign addr_vld  = HSEL & HREADY & HTRANS[1];
    assign HREADYOUT = 1'b1;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_q <= 8'h00;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            if (addr_vld) begin
                addr_q <= HADDR[7:0];
            end
            wr_q <= addr_vld & HWRITE & (HSIZE == 3'b010);
            rd_q <= addr_vld & ~HWRITE;
        end
    end

    // Upper address bits and the SEQ/NONSEQ distinction are intentionally not decoded.
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:8], HTRANS[0]};

    // ------------------------------------------------------------------
    // Data phase decode
    // ------------------------------------------------------------------
    logic [3:0] ch_sel;
    logic [1:0] off_sel;
    logic       aligned;
    logic       irq_pend_hit;

    assign ch_sel       = addr_q[7:4];
    assign off_sel      = addr_q[3:2];
    assign aligned      = (addr_q[1:0] == 2'b00);
    assign irq_pend_hit = (addr_q == 8'(NUM_CH * 16));

    // Per-channel state, gathered for the read mux and irq reduction
    logic [NUM_CH-1:0]    ch_hit;
    logic [NUM_CH-1:0]    en_v;
    logic [NUM_CH-1:0]    mode_v;
    logic [NUM_CH-1:0]    irq_en_v;
    logic [NUM_CH-1:0]    expired_v;
    logic [PRE_WIDTH-1:0] prescale_a [NUM_CH];
    logic [CNT_WIDTH-1:0] load_a     [NUM_CH];
    logic [CNT_WIDTH-1:0] value_a    [NUM_CH];

    // ------------------------------------------------------------------
    // Timer channels
    // ------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [3:0] CH_IDX = 4'(c);

        logic                 en_q;
        logic                 mode_q;
        logic                 irq_en_q;
        logic                 expired_q;
        logic                 done_q;
        logic [PRE_WIDTH-1:0] prescale_q;
        logic [PRE_WIDTH-1:0] presc_cnt_q;
        logic [CNT_WIDTH-1:0] load_q;
        logic [CNT_WIDTH-1:0] value_q;

        logic ctrl_wr;
        logic load_wr;
        logic stat_wr;
        logic start;
        logic tick;
        logic expire;

        assign ch_hit[c] = aligned & (ch_sel == CH_IDX);
        assign ctrl_wr   = wr_q & ch_hit[c] & (off_sel == 2'd0);
        assign load_wr   = wr_q & ch_hit[c] & (off_sel == 2'd1);
        assign stat_wr   = wr_q & ch_hit[c] & (off_sel == 2'd3);

        // Only a 0->1 EN transition restarts; rewriting EN=1 just updates the fields.
        assign start  = ctrl_wr & HWDATA[0] & ~en_q;

        // ">=" so that a PRESCALE narrowed below the running count wraps on the next cycle.
        assign tick   = en_q & (presc_cnt_q >= prescale_q);
        assign expire = tick & (value_q == '0);

        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                en_q        <= 1'b0;
                mode_q      <= 1'b0;
                irq_en_q    <= 1'b0;
                expired_q   <= 1'b0;
                done_q      <= 1'b0;
                prescale_q  <= '0;
                presc_cnt_q <= '0;
                load_q      <= '0;
                value_q     <= '0;
            end else begin
                if (ctrl_wr) begin
                    en_q       <= HWDATA[0];
                    mode_q     <= HWDATA[1];
                    irq_en_q   <= HWDATA[2];
                    prescale_q <= HWDATA[8 +: PRE_WIDTH];
                end else if (expire && !mode_q) begin
                    en_q <= 1'b0;   // one-shot stops itself
                end

                if (load_wr) begin
                    load_q <= HWDATA[CNT_WIDTH-1:0];
                end

                if (start) begin
                    value_q     <= load_q;
                    presc_cnt_q <= '0;
                end else if (en_q) begin
                    if (tick) begin
                        presc_cnt_q <= '0;
                        if (value_q == '0) begin
                            if (mode_q) begin
                                value_q <= load_q;
                            end
                        end else begin
                            value_q <= value_q - CNT_WIDTH'(1);
                        end
                    end else begin
                        presc_cnt_q <= presc_cnt_q + PRE_WIDTH'(1);
                    end
                end

                // Set has priority over a simultaneous write-1-to-clear.
                expired_q <= (expired_q & ~(stat_wr & HWDATA[0])) | expire;
                done_q    <= expire;
            end
        end

        assign en_v[c]       = en_q;
        assign mode_v[c]     = mode_q;
        assign irq_en_v[c]   = irq_en_q;
        assign expired_v[c]  = expired_q;
        assign prescale_a[c] = prescale_q;
        assign load_a[c]     = load_q;
        assign value_a[c]    = value_q;
        assign done[c]       = done_q;
    end

    // ------------------------------------------------------------------
    // Interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            irq <= 1'b0;
        end else begin
            irq <= |(expired_v & irq_en_v);
        end
    end

    // ------------------------------------------------------------------
    // Read mux, driven from the captured address during the data phase
    // ------------------------------------------------------------------
    always_comb begin
        HRDATA = 32'h0;
        if (rd_q) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_hit[c]) begin
                    case (off_sel)
                        2'd0: begin
                            HRDATA[0]               = en_v[c];
                            HRDATA[1]               = mode_v[c];
                            HRDATA[2]               = irq_en_v[c];
                            HRDATA[8 +: PRE_WIDTH]  = prescale_a[c];
                        end
                        2'd1:    HRDATA[CNT_WIDTH-1:0] = load_a[c];
                        2'd2:    HRDATA[CNT_WIDTH-1:0] = value_a[c];
                        default: HRDATA[0]             = expired_v[c];
                    endcase
                end
            end
            if (irq_pend_hit) begin
                HRDATA[NUM_CH-1:0] = expired_v & irq_en_v;
            end
        end
    end

endmodule

// File: tb/tb_ahb_multi_timer.sv
// Directed bench for ahb_multi_timer with a read-data scoreboard.
// Latency: reads compared in the data phase, one cycle after the address phase.
// Backpressure: none exercised, HREADY held high.
module tb_ahb_multi_timer;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic        HREADY;
    logic        HSEL;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [3:0]  done;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    ahb_multi_timer #(.NUM_CH(4), .CNT_WIDTH(32), .PRE_WIDTH(8)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HREADY    (HREADY),
        .HSEL      (HSEL),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .done      (done),
        .irq       (irq)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
    endtask

    // Called #1 after an edge; returns #1 after the edge on which the write committed.
    task automatic ahb_write(input logic [7:0] a, input logic [31:0] d, input logic [2:0] sz);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b1;
        HADDR  = {24'h0, a};
        HSIZE  = sz;
        @(posedge HCLK); #1;
        bus_idle();
        HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic sb_check();
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL scoreboard_empty observed=0x%08h expected=none", HRDATA);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, HRDATA, e);
        end
    endtask

    // Address phase now, compare in the data phase one cycle later.
    task automatic ahb_read(input logic [7:0] a, input logic [31:0] e, input string tag);
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HWRITE = 1'b0;
        HADDR  = {24'h0, a};
        HSIZE  = 3'b010;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge HCLK); #1;
        bus_idle();
        sb_check();
    endtask

    initial begin
        logic [3:0] done_seen;

        HRESET = 1'b1;
        HADDR  = '0;
        HWDATA = '0;
        HSIZE  = 3'b010;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HREADY = 1'b1;
        HSEL   = 1'b0;

        // ---- 1: reset ----
        for (int i = 0; i < 3; i++) begin
            @(posedge HCLK); #1;
            check("rst_done",   32'(done), 32'h0);
            check("rst_irq",    32'(irq), 32'h0);
            check("rst_hready", 32'(HREADYOUT), 32'h1);
            check("rst_hrdata", HRDATA, 32'h0);
        end
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        ahb_read(8'h00, 32'h0, "rst_ctrl0");
        ahb_read(8'h04, 32'h0, "rst_load0");
        ahb_read(8'h08, 32'h0, "rst_value0");
        ahb_read(8'h0C, 32'h0, "rst_status0");
        ahb_read(8'h40, 32'h0, "rst_irq_pend");
        check("rst_hready_after", 32'(HREADYOUT), 32'h1);

        // ---- 2: one-shot, expiry 6 cycles after commit ----
        ahb_write(8'h04, 32'd5, 3'b010);
        ahb_write(8'h00, 32'h1, 3'b010);
        for (int k = 1; k <= 8; k++) begin
            @(posedge HCLK); #1;
            check($sformatf("oneshot_done_c%0d", k), 32'(done), (k == 6) ? 32'h1 : 32'h0);
        end
        ahb_read(8'h08, 32'h0, "oneshot_value");
        ahb_read(8'h00, 32'h0, "oneshot_ctrl_en_off");
        ahb_read(8'h0C, 32'h1, "oneshot_status");

        // ---- 3: periodic, LOAD=3 PRESCALE=2 -> period 12 ----
        ahb_write(8'h14, 32'd3, 3'b010);
        ahb_write(8'h10, 32'h0203, 3'b010);
        for (int k = 1; k <= 60; k++) begin
            @(posedge HCLK); #1;
            check($sformatf("periodic_done_c%0d", k), 32'(done), (k % 12 == 0) ? 32'h2 : 32'h0);
        end
        ahb_read(8'h10, 32'h0203, "periodic_ctrl");
        ahb_write(8'h10, 32'h0, 3'b010);
        check("periodic_irq_off", 32'(irq), 32'h0);

        // ---- 4: irq and write-1-to-clear ----
        ahb_write(8'h24, 32'd0, 3'b010);
        ahb_write(8'h20, 32'h7, 3'b010);
        @(posedge HCLK); #1;
        check("irq_done2", 32'(done), 32'h4);
        @(posedge HCLK); #1;
        check("irq_set", 32'(irq), 32'h1);
        ahb_read(8'h40, 32'h4, "irq_pend");
        ahb_write(8'h2C, 32'h1, 3'b010);       // clear collides with an expiry
        ahb_read(8'h2C, 32'h1, "w1c_set_wins");
        check("irq_held", 32'(irq), 32'h1);
        ahb_write(8'h20, 32'h4, 3'b010);       // stop, keep IRQ_EN
        check("irq_after_stop", 32'(irq), 32'h1);
        ahb_write(8'h2C, 32'h1, 3'b010);
        @(posedge HCLK); #1;
        check("irq_cleared", 32'(irq), 32'h0);
        check("irq_done_idle", 32'(done), 32'h0);
        ahb_read(8'h40, 32'h0, "irq_pend_cleared");

        // ---- 5: bus edges ----
        ahb_write(8'h04, 32'hAB, 3'b000);      // byte write ignored
        ahb_read(8'h04, 32'd5, "byte_write_ignored");
        ahb_read(8'hF0, 32'h0, "unmapped_read");
        ahb_write(8'h08, 32'h7, 3'b010);       // VALUE is read-only
        ahb_read(8'h08, 32'h0, "value_ro");
        // back-to-back write LOAD then read LOAD
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h34; HSIZE = 3'b010;
        @(posedge HCLK); #1;
        HWDATA = 32'h1234_5678;
        HWRITE = 1'b0; HADDR = 32'h34;
        exp_q.push_back(32'h1234_5678);
        tag_q.push_back("b2b_write_read");
        @(posedge HCLK); #1;
        bus_idle();
        sb_check();

        // ---- 6: mid-run reset ----
        ahb_write(8'h34, 32'd1000, 3'b010);
        ahb_write(8'h30, 32'h1, 3'b010);
        repeat (500) @(posedge HCLK);
        #1;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        HRESET = 1'b0;
        ahb_read(8'h38, 32'h0, "midrst_value");
        ahb_read(8'h30, 32'h0, "midrst_ctrl");
        ahb_read(8'h34, 32'h0, "midrst_load");
        done_seen = '0;
        for (int k = 0; k < 700; k++) begin
            @(posedge HCLK); #1;
            done_seen = done_seen | done;
        end
        check("midrst_no_done", 32'(done_seen), 32'h0);
        ahb_read(8'h0C, 32'h0, "midrst_status0");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
